spi_xfer_ctrl: RTL and testbench

Byte-transfer sequencer sitting directly upstream of `spi_master`. Host logic queues bytes into a TX FIFO. The block drives each byte through `spi_master`'s send handshake, then runs one read handshake, and queues the received byte into an RX FIFO. It turns `spi_master`'s level-held request/busy protocol into simple FIFO push/pop ports.

---
 rtl/spi_xfer_pkg.sv | 16 +
 rtl/spi_xfer_ctrl_if.sv | 23 ++
 rtl/spi_xfer_ctrl_sync_fifo.sv | 68 ++++++
 rtl/spi_xfer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_pkg.sv
// Shared types and widths for the SPI byte-transfer sequencer.
package spi_xfer_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_REQ  = 3'd1,
    SEND_WAIT = 3'd2,
    READ_REQ  = 3'd3,
    READ_WAIT = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Request/busy handshake between the sequencer (master) and spi_master (slave).
interface spi_xfer_ctrl_if;
  import spi_xfer_pkg::*;

  logic      m_send;
  spi_byte_t m_send_data;
  logic      m_send_busy;
  logic      m_read;
  logic      m_recv_busy;
  logic      m_recv_rdy;
  spi_byte_t m_recv_data;

  modport master (
    output m_send, m_send_data, m_read,
    input  m_send_busy, m_recv_busy, m_recv_rdy, m_recv_data
  );

  modport slave (
    input  m_send, m_send_data, m_read,
    output m_send_busy, m_recv_busy, m_recv_rdy, m_recv_data
  );

endinterface

// File: rtl/spi_xfer_ctrl_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags; head is read combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             full_q;
  logic             empty_q;
  logic             do_wr;
  logic             do_rd;

  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign do_rd = rd_i && !empty_q;
  assign do_wr = wr_i && (!full_q || do_rd);

  always_comb begin
    level_d = level_q;
    if (do_wr && !do_rd) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_wr && do_rd) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_rd) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Byte-transfer sequencer: TX FIFO -> spi_master send/read handshakes -> RX FIFO.
// Define SPI_XFER_CTRL_TIMEOUT_EN to abort stalled requests and raise the sticky err flag.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tx_wr,
  input  spi_byte_t       tx_data,
  output logic            tx_full,
  input  logic            rx_rd,
  output spi_byte_t       rx_data,
  output logic            rx_empty,
  output logic            busy,
  output logic            err,
  input  logic            err_clr,
  spi_xfer_ctrl_if.master spi
);

  xfer_state_e state_q;
  logic        busy_q;
  logic        send_q;
  logic        read_q;
  spi_byte_t   send_data_q;
  logic        rdy_q;
  logic        rdy_prev_q;
  spi_byte_t   recv_data_q;

  logic        tx_empty;
  logic        rx_full;
  spi_byte_t   tx_head;
  logic        tx_pop;
  logic        rx_push;
  logic        rdy_rise;
  logic        tmo;

  // RX space is checked only here, so a started transfer always has a slot to land in.
  assign tx_pop   = (state_q == IDLE) && !tx_empty && !rx_full;
  assign rdy_rise = rdy_q && !rdy_prev_q;
  assign rx_push  = (state_q == READ_WAIT) && rdy_rise;

  sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (tx_wr),
    .wdata_i (tx_data),
    .rd_i    (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (rx_push),
    .wdata_i (recv_data_q),
    .rd_i    (rx_rd),
    .rdata_o (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             req_wait;
  logic             err_q;

  // Counts only while a request waits for its busy; any state change restarts it.
  assign req_wait = ((state_q == SEND_REQ) && !spi.m_send_busy) ||
                    ((state_q == READ_REQ) && !spi.m_recv_busy);
  assign tmo      = req_wait && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (req_wait && !tmo) ? cnt_q + CNT_W'(1) : '0;
      if (tmo) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;

  assign tmo        = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = err_clr & (TIMEOUT != 0);
`endif

  // Sequencer FSM; all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      send_q      <= 1'b0;
      read_q      <= 1'b0;
      send_data_q <= '0;
      rdy_q       <= 1'b0;
      rdy_prev_q  <= 1'b0;
      recv_data_q <= '0;
    end else begin
      rdy_q       <= spi.m_recv_rdy;
      rdy_prev_q  <= rdy_q;
      recv_data_q <= spi.m_recv_data;
      unique case (state_q)
        IDLE: begin
          if (tx_pop) begin
            send_data_q <= tx_head;
            send_q      <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SEND_REQ;
          end
        end
        SEND_REQ: begin
          if (spi.m_send_busy) begin
            send_q  <= 1'b0;
            state_q <= SEND_WAIT;
          end else if (tmo) begin
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SEND_WAIT: begin
          if (!spi.m_send_busy) begin
            read_q  <= 1'b1;
            state_q <= READ_REQ;
          end
        end
        READ_REQ: begin
          if (spi.m_recv_busy) begin
            read_q  <= 1'b0;
            state_q <= READ_WAIT;
          end else if (tmo) begin
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        READ_WAIT: begin
          if (rdy_rise) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          send_q  <= 1'b0;
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign spi.m_send      = send_q;
  assign spi.m_send_data = send_data_q;
  assign spi.m_read      = read_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl with a behavioural spi_master stand-in and queue scoreboard.
module tb_spi_xfer_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       busy;
  logic       err;
  logic       err_clr;

  spi_xfer_ctrl_if sif ();

  spi_xfer_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .rx_rd    (rx_rd),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr),
    .spi      (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: bytes the master must see, and bytes the host must read back, in order.
  logic [7:0] exp_send[$];
  logic [7:0] exp_rx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fake spi_master, acting on falling edges.
  int         fm_ph = 0;
  int         fm_cnt = 0;
  bit         fm_en = 1'b0;
  bit         fm_kill = 1'b0;
  bit         fm_rand = 1'b0;
  logic [7:0] fm_rx_val = 8'h00;
  int         sb_dly = 2, sb_len = 8, rb_dly = 2, rb_len = 8;

  initial begin : fake_master
    sif.m_send_busy = 1'b0;
    sif.m_recv_busy = 1'b0;
    sif.m_recv_rdy  = 1'b0;
    sif.m_recv_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!fm_en || fm_kill) begin
        sif.m_send_busy = 1'b0;
        sif.m_recv_busy = 1'b0;
        sif.m_recv_rdy  = 1'b0;
        fm_ph = 0;
      end else begin
        case (fm_ph)
          0: if (sif.m_send) begin
            if (exp_send.size() == 0) fail_now("unexpected_send");
            else chk("send_order", sif.m_send_data, exp_send.pop_front());
            if (fm_rand) begin
              sb_dly = $urandom_range(4, 1);
              sb_len = $urandom_range(5, 1);
              rb_dly = $urandom_range(4, 1);
              rb_len = $urandom_range(5, 1);
            end
            fm_cnt = sb_dly;
            fm_ph  = 1;
          end
          1: if (fm_cnt <= 1) begin
            sif.m_send_busy = 1'b1; fm_cnt = sb_len; fm_ph = 2;
          end else fm_cnt--;
          2: if (fm_cnt <= 1) begin
            sif.m_send_busy = 1'b0; fm_ph = 3;
          end else fm_cnt--;
          3: if (sif.m_read) begin
            fm_cnt = rb_dly; fm_ph = 4;
          end
          4: if (fm_cnt <= 1) begin
            sif.m_recv_busy = 1'b1; fm_cnt = rb_len; fm_ph = 5;
          end else fm_cnt--;
          5: if (fm_cnt <= 1) begin
            sif.m_recv_busy = 1'b0;
            sif.m_recv_data = fm_rand ? 8'($urandom) : fm_rx_val;
            sif.m_recv_rdy  = 1'b1;
            exp_rx.push_back(sif.m_recv_data);
            fm_ph = 6;
          end else fm_cnt--;
          default: begin
            sif.m_recv_rdy = 1'b0;
            fm_ph = 0;
          end
        endcase
      end
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    fm_kill = 1'b1;
    tx_wr   = 1'b0;
    rx_rd   = 1'b0;
    err_clr = 1'b0;
    tick();
    rst_n   = 1'b1;
    fm_kill = 1'b0;
    exp_send.delete();
    exp_rx.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_full"}, tx_full, 0);
    chk({tag, "_rx_empty"}, rx_empty, 1);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_m_send"}, sif.m_send, 0);
    chk({tag, "_m_send_data"}, sif.m_send_data, 0);
    chk({tag, "_m_read"}, sif.m_read, 0);
  endtask

  task automatic push_byte(input logic [7:0] d);
    int c = 0;
    while (tx_full && c < 500) begin tick(); c++; end
    if (tx_full) fail_now("push_wait_timeout");
    tx_wr = 1'b1;
    tx_data = d;
    exp_send.push_back(d);
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic collect_rx(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      if (!rx_empty) begin
        if (exp_rx.size() == 0) fail_now("rx_extra");
        else chk("rx_data", rx_data, exp_rx.pop_front());
        rx_rd = 1'b1;
        got++;
      end
      tick();
      rx_rd = 1'b0;
      cyc++;
    end
    if (got < n) fail_now("collect_rx_timeout");
  endtask

  task automatic wait_rx_count(input int n, input int budget);
    int c = 0;
    while (exp_rx.size() < n && c < budget) begin tick(); c++; end
    if (exp_rx.size() < n) fail_now("wait_rx_count_timeout");
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       acc;
    logic       e_full;
    logic       e_busy;
    logic       e_send;
    logic [7:0] e_sdata;
  } vec_t;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t       vt[7];
    logic [7:0] pushed[8];
    logic [7:0] xb;
    int         c;
    int         viol;

    // TX fill with the master unresponsive: first byte is popped, four more fill the FIFO.
    vt[0] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01};
    vt[2] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01};
    vt[3] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01};
    vt[4] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01};
    vt[5] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};

    rst_n = 1'b0; tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; err_clr = 1'b0;
    tick();
    do_reset();
    chk_reset_vals("rst");

    // Table-driven TX fill
    fm_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tx_wr = vt[i].wr;
      tx_data = vt[i].d;
      if (vt[i].wr && vt[i].acc) exp_send.push_back(vt[i].d);
      tick();
      tx_wr = 1'b0;
      chk($sformatf("tbl%0d_tx_full", i), tx_full, vt[i].e_full);
      chk($sformatf("tbl%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("tbl%0d_m_send", i), sif.m_send, vt[i].e_send);
      chk($sformatf("tbl%0d_m_send_data", i), sif.m_send_data, vt[i].e_sdata);
    end
    fm_en = 1'b1; fm_rand = 1'b1;
    collect_rx(5, 2000);
    chk("tbl_all_sent", exp_send.size(), 0);

    // Single transfer with fixed handshake timing
    fm_rand = 1'b0; sb_dly = 2; sb_len = 8; rb_dly = 2; rb_len = 8; fm_rx_val = 8'h3C;
    do_reset();
    tx_wr = 1'b1; tx_data = 8'hAA; exp_send.push_back(8'hAA);
    tick();
    tx_wr = 1'b0;
    tick();
    chk("st_m_send_rise", sif.m_send, 1);
    c = 0;
    while (sif.m_send && c < 40) begin
      chk("st_send_data", sif.m_send_data, 8'hAA);
      tick(); c++;
    end
    c = 0;
    while (!sif.m_recv_rdy && c < 100) begin tick(); c++; end
    chk("st_rdy_seen", sif.m_recv_rdy, 1);
    chk("st_busy_at_rdy", busy, 1);
    chk("st_rx_empty_at_rdy", rx_empty, 1);
    tick();
    chk("st_busy_after", busy, 0);
    chk("st_rx_empty_after", rx_empty, 0);
    chk("st_rx_data", rx_data, 8'h3C);
    collect_rx(1, 20);

    // RX full stall, then one pop allows one transfer
    fm_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    wait_rx_count(4, 600);
    repeat (5) tick();
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy || sif.m_send) viol++;
      tick();
    end
    chk("stall_idle", viol, 0);
    chk("stall_rx_count", exp_rx.size(), 4);
    chk("stall_pop_data", rx_data, exp_rx.pop_front());
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    tick();
    chk("stall_resume", busy, 1);
    c = 0;
    while (busy && c < 200) begin tick(); c++; end
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) viol++;
      tick();
    end
    chk("stall_one_more", viol, 0);
    chk("stall_rx_count2", exp_rx.size(), 4);
    collect_rx(5, 2000);
    chk("stall_all_sent", exp_send.size(), 0);

    // Push and IDLE pop on the same edge while TX is full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pushed[i] = 8'($urandom);
      push_byte(pushed[i]);
    end
    wait_rx_count(4, 600);
    repeat (5) tick();
    for (int i = 4; i < 8; i++) begin
      pushed[i] = 8'($urandom);
      push_byte(pushed[i]);
    end
    tick();
    chk("pp_tx_full", tx_full, 1);
    chk("pp_stalled", busy, 0);
    chk("pp_rx_head", rx_data, exp_rx.pop_front());
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    xb = 8'($urandom);
    tx_wr = 1'b1; tx_data = xb; exp_send.push_back(xb);
    tick();
    tx_wr = 1'b0;
    chk("pp_tx_full_kept", tx_full, 1);
    chk("pp_m_send", sif.m_send, 1);
    chk("pp_m_send_data", sif.m_send_data, pushed[4]);
    collect_rx(8, 3000);
    chk("pp_all_sent", exp_send.size(), 0);

    // Reset during SEND_WAIT, with a byte still queued
    do_reset();
    push_byte(8'h11);
    push_byte(8'h22);
    c = 0;
    while (!(sif.m_send_busy && !sif.m_send) && c < 50) begin tick(); c++; end
    chk("mr_in_send_wait", sif.m_send_busy && !sif.m_send, 1);
    do_reset();
    chk_reset_vals("mr_sw");
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || sif.m_send) viol++;
      tick();
    end
    chk("mr_sw_tx_flushed", viol, 0);

    // Reset during READ_WAIT, after a byte has landed in RX
    push_byte(8'h33);
    collect_rx(0, 1);
    wait_rx_count(1, 200);
    tick(); tick();
    push_byte(8'h44);
    c = 0;
    while (!(sif.m_recv_busy && !sif.m_read) && c < 80) begin tick(); c++; end
    chk("mr_in_read_wait", sif.m_recv_busy && !sif.m_read, 1);
    do_reset();
    chk_reset_vals("mr_rw");
    repeat (20) tick();
    chk("mr_rw_rx_flushed", rx_empty, 1);
    chk("mr_rw_idle", busy, 0);

    // Request timeout / err behaviour
    fm_en = 1'b0;
    do_reset();
    tx_wr = 1'b1; tx_data = 8'h5A; tick(); tx_wr = 1'b0;
    tick();
    chk("to_m_send", sif.m_send, 1);
`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    chk("to_err_early", err, 0);
    chk("to_m_send_held", sif.m_send, 1);
    tick();
    chk("to_err_set", err, 1);
    chk("to_m_send_drop", sif.m_send, 0);
    chk("to_idle", busy, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_err_clr", err, 0);
`else
    repeat (3 * TIMEOUT) tick();
    chk("to_err_never", err, 0);
    chk("to_m_send_waits", sif.m_send, 1);
    chk("to_busy_waits", busy, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_err_clr_ignored", err, 0);
`endif
    fm_en = 1'b1;

    // Randomized traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!rx_empty && $urandom_range(1, 0) == 1) begin
        if (exp_rx.size() == 0) fail_now("rnd_rx_extra");
        else chk("rnd_rx_data", rx_data, exp_rx.pop_front());
        rx_rd = 1'b1;
      end
      if (!tx_full && $urandom_range(3, 0) == 0) begin
        tx_data = 8'($urandom);
        tx_wr = 1'b1;
        exp_send.push_back(tx_data);
      end
      tick();
      rx_rd = 1'b0;
      tx_wr = 1'b0;
    end
    c = 0;
    while ((exp_send.size() != 0 || busy) && c < 2000) begin
      if (!rx_empty) begin
        if (exp_rx.size() == 0) fail_now("rnd_rx_extra");
        else chk("rnd_rx_data", rx_data, exp_rx.pop_front());
        rx_rd = 1'b1;
      end
      tick(); rx_rd = 1'b0; c++;
    end
    collect_rx(exp_rx.size(), 200);
    chk("rnd_all_sent", exp_send.size(), 0);
    chk("rnd_rx_drained", rx_empty, 1);
    chk("rnd_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
